// File: rtl/fifo_param_pkg.sv
// Shared defaults for the FIFO family: word width, pointer width,
// flag thresholds and depth/count-width helpers.
package fifo_param_pkg;

    localparam int DEF_DATA_WIDTH      = 10;
    localparam int DEF_ADDR_WIDTH      = 3;
    localparam int DEF_ALMOST_FULL_TH  = 6;
    localparam int DEF_ALMOST_EMPTY_TH = 2;

    // Number of words addressed by a pointer of the given width.
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    // Occupancy needs one extra bit so that full and empty differ.
    function automatic int count_width(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage for fifo_param: one write port, one registered read port.
// Neither the array nor the read register is reset.
module fifo_ram #(
    parameter int DW = 10,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    // Registered read; holds its value when no read is requested.
    always_ff @(posedge clk) begin
        if (re) rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with count, full/empty and almost flags.
// Define FIFO_ERR_EN to add sticky overflow/underflow outputs.
module fifo_param
    import fifo_param_pkg::*;
#(
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int ALMOST_FULL_TH  = DEF_ALMOST_FULL_TH,
    parameter int ALMOST_EMPTY_TH = DEF_ALMOST_EMPTY_TH
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  wr_enable,
    input  logic [DATA_WIDTH-1:0] FIFO_data_in,
    input  logic                  rd_enable,
    output logic [DATA_WIDTH-1:0] FIFO_data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int CW    = count_width(ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  dout_vld_q;
    logic                  rd_acc, wr_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    assign rd_acc = rd_enable & ~empty;
    assign wr_acc = wr_enable & (~full | rd_acc);

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers; dout_vld_q forces zero output until
    // the first read after reset refreshes the RAM read register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (rd_acc) dout_vld_q <= 1'b1;
        end
    end

    fifo_ram #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (FIFO_data_in),
        .re    (rd_acc),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    assign FIFO_data_out = dout_vld_q ? ram_rdata : '0;
    assign count         = count_q;
    assign full          = (count_q == CW'(DEPTH));
    assign empty         = (count_q == '0);
    assign almost_full   = (count_q >= CW'(ALMOST_FULL_TH));
    assign almost_empty  = (count_q <= CW'(ALMOST_EMPTY_TH));

`ifdef FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    assign ovf_d = ovf_q | (wr_enable & ~wr_acc);
    assign unf_d = unf_q | (rd_enable & empty);

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param against a queue-based model.
// Also checks overflow/underflow when built with FIFO_ERR_EN.
module tb_fifo_param;

    localparam int DW = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          wr_enable = 1'b0;
    logic [DW-1:0] FIFO_data_in = '0;
    logic          rd_enable = 1'b0;
    logic [DW-1:0] FIFO_data_out;
    logic          full, empty, almost_full, almost_empty;
    logic [3:0]    count;
`ifdef FIFO_ERR_EN
    logic          overflow, underflow;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW-1:0] mq[$];
    logic [DW-1:0] mdout = '0;
    logic          movf = 1'b0;
    logic          munf = 1'b0;

    fifo_param dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .wr_enable     (wr_enable),
        .FIFO_data_in  (FIFO_data_in),
        .rd_enable     (rd_enable),
        .FIFO_data_out (FIFO_data_out),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .count         (count)
`ifdef FIFO_ERR_EN
        ,
        .overflow      (overflow),
        .underflow     (underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        mdout = '0;
        movf  = 1'b0;
        munf  = 1'b0;
    endtask

    // One clock of stimulus; the model applies the queue semantics
    // of the FIFO using the state seen before the edge.
    task automatic step(input logic we, input logic [DW-1:0] wd,
                        input logic re);
        bit racc, wacc;
        wr_enable    = we;
        FIFO_data_in = wd;
        rd_enable    = re;
        @(posedge clk);
        racc = re && (mq.size() > 0);
        wacc = we && ((mq.size() < DEPTH) || racc);
        if (re && mq.size() == 0) munf = 1'b1;
        if (we && !wacc) movf = 1'b1;
        if (racc) mdout = mq.pop_front();
        if (wacc) mq.push_back(wd);
        #1;
        wr_enable = 1'b0;
        rd_enable = 1'b0;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        model_reset();
        #7;
        reset_L = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        model_reset();
        #3;
        tests_run++;
        if ({count, empty, almost_empty, full, almost_full} !== {4'd0, 4'b1100}) begin
            tests_failed++;
            $display("FAIL reset_state got cnt=%0d e=%b ae=%b f=%b af=%b want 0 1 1 0 0",
                     count, empty, almost_empty, full, almost_full);
        end
        tests_run++;
        if (FIFO_data_out !== 10'h000) begin
            tests_failed++;
            $display("FAIL reset_dout got %h want 000", FIFO_data_out);
        end
`ifdef FIFO_ERR_EN
        tests_run++;
        if ({overflow, underflow} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_err got %b want 00", {overflow, underflow});
        end
`endif
        #4;
        reset_L = 1'b1;
        #1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
        tests_run++;
        if ({full, almost_full, count} !== {2'b11, 4'd8}) begin
            tests_failed++;
            $display("FAIL fill_flags got f=%b af=%b cnt=%0d want 1 1 8",
                     full, almost_full, count);
        end
        step(1'b1, 10'h3FF, 1'b0);
        tests_run++;
        if ({full, count} !== {1'b1, 4'd8}) begin
            tests_failed++;
            $display("FAIL fill_9th got f=%b cnt=%0d want 1 8", full, count);
        end
`ifdef FIFO_ERR_EN
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow got %b want 1", overflow);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, '0, 1'b1);
            tests_run++;
            if (FIFO_data_out !== DW'(i)) begin
                tests_failed++;
                $display("FAIL drain_data[%0d] got %h want %h", i, FIFO_data_out, DW'(i));
            end
        end
        tests_run++;
        if ({empty, count} !== {1'b1, 4'd0}) begin
            tests_failed++;
            $display("FAIL drain_empty got e=%b cnt=%0d want 1 0", empty, count);
        end
        step(1'b0, '0, 1'b1);
        tests_run++;
        if (FIFO_data_out !== 10'h008) begin
            tests_failed++;
            $display("FAIL drain_9th got %h want 008", FIFO_data_out);
        end
`ifdef FIFO_ERR_EN
        tests_run++;
        if (underflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL underflow got %b want 1", underflow);
        end
`endif
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] exp;
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b1, 10'h155, 1'b1);
        tests_run++;
        if ({count, FIFO_data_out} !== {4'd8, 10'h001}) begin
            tests_failed++;
            $display("FAIL full_rw got cnt=%0d d=%h want 8 001", count, FIFO_data_out);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1);
            exp = (i == 7) ? 10'h155 : DW'(i + 2);
            tests_run++;
            if (FIFO_data_out !== exp) begin
                tests_failed++;
                $display("FAIL full_rw_drain[%0d] got %h want %h", i, FIFO_data_out, exp);
            end
        end
    endtask

    task automatic test_empty_rw();
        step(1'b1, 10'h0AA, 1'b1);
        tests_run++;
        if ({count, FIFO_data_out} !== {4'd1, 10'h155}) begin
            tests_failed++;
            $display("FAIL empty_rw got cnt=%0d d=%h want 1 155", count, FIFO_data_out);
        end
        step(1'b0, '0, 1'b1);
        tests_run++;
        if ({count, FIFO_data_out} !== {4'd0, 10'h0AA}) begin
            tests_failed++;
            $display("FAIL empty_rw_read got cnt=%0d d=%h want 0 0aa", count, FIFO_data_out);
        end
    endtask

    task automatic test_wrap();
        logic [DW-1:0] d;
        for (int i = 0; i < 20; i++) begin
            d = DW'($urandom);
            step(1'b1, d, 1'b0);
            tests_run++;
            if ({count, empty, almost_empty} !== {4'd1, 2'b01}) begin
                tests_failed++;
                $display("FAIL wrap_wr[%0d] got cnt=%0d e=%b ae=%b want 1 0 1",
                         i, count, empty, almost_empty);
            end
            step(1'b0, '0, 1'b1);
            tests_run++;
            if ({count, FIFO_data_out} !== {4'd0, d}) begin
                tests_failed++;
                $display("FAIL wrap_rd[%0d] got cnt=%0d d=%h want 0 %h",
                         i, count, FIFO_data_out, d);
            end
        end
    endtask

    task automatic test_thresholds();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, DW'($urandom), 1'b0);
            tests_run++;
            if ({almost_full, almost_empty} !== {k >= 6, k <= 2}) begin
                tests_failed++;
                $display("FAIL thr_up[%0d] got af=%b ae=%b want %b %b",
                         k, almost_full, almost_empty, k >= 6, k <= 2);
            end
        end
        for (int k = 7; k >= 0; k--) begin
            step(1'b0, '0, 1'b1);
            tests_run++;
            if ({almost_full, almost_empty} !== {k >= 6, k <= 2}) begin
                tests_failed++;
                $display("FAIL thr_dn[%0d] got af=%b ae=%b want %b %b",
                         k, almost_full, almost_empty, k >= 6, k <= 2);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1'b1, DW'(10'h100 + i), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b1, 10'h123, 1'b0);
        reset_L = 1'b0;
        #2;
        tests_run++;
        if ({count, empty, FIFO_data_out} !== {4'd0, 1'b1, 10'h000}) begin
            tests_failed++;
            $display("FAIL async_rst got cnt=%0d e=%b d=%h want 0 1 000",
                     count, empty, FIFO_data_out);
        end
        model_reset();
        #3;
        reset_L = 1'b1;
        step(1'b1, 10'h2C3, 1'b0);
        step(1'b0, '0, 1'b1);
        tests_run++;
        if ({count, FIFO_data_out} !== {4'd0, 10'h2C3}) begin
            tests_failed++;
            $display("FAIL post_rst_read got cnt=%0d d=%h want 0 2c3", count, FIFO_data_out);
        end
    endtask

    task automatic test_random();
        logic [18:0] got, exp;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 100) < 55, DW'($urandom), ($urandom % 100) < 45);
            got = {count, full, empty, almost_full, almost_empty, FIFO_data_out};
            exp = {4'(mq.size()), mq.size() == DEPTH, mq.size() == 0,
                   mq.size() >= 6, mq.size() <= 2, mdout};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                if (bad < 5)
                    $display("FAIL random[%0d] got %h want %h", i, got, exp);
                bad++;
            end
`ifdef FIFO_ERR_EN
            tests_run++;
            if ({overflow, underflow} !== {movf, munf}) begin
                tests_failed++;
                $display("FAIL random_err[%0d] got %b want %b",
                         i, {overflow, underflow}, {movf, munf});
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        do_reset();
        test_full_rw();
        test_empty_rw();
        test_wrap();
        test_thresholds();
        test_async_reset();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
